// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell per clock, LSB first, IDLE -> RUN -> DONE.
// The sum and carry-out registers hold the last published result until the next one.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must reach WIDTH-1; $clog2 of WIDTH >= 2 always suffices.
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic [WIDTH-2:0]   psum_r;
  logic [WIDTH-1:0]   psum_next_s;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         fa_s;
  logic               last_bit_s;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;

  // Returns {carry, sum} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic s;
    logic co;
    s  = x ^ y ^ c;
    co = (x & y) | (c & (x ^ y));
    return {co, s};
  endfunction

  // One-bit adder cell, partial-sum shift value and last-bit detect.
  always_comb begin
    fa_s        = full_add(opa_r[0], opb_r[0], carry_r);
    psum_next_s = {fa_s[0], psum_r};
    last_bit_s  = (cnt_r == CNT_W'(WIDTH - 1));
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with registered status flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Operand shifting, carry/counter update and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      psum_r  <= {(WIDTH-1){1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            opa_r   <= a;
            opb_r   <= b;
            carry_r <= cin;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            opa_r   <= opa_r;
            opb_r   <= opb_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
          end
        end
        ST_RUN: begin
          opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
          opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
          psum_r  <= psum_next_s[WIDTH-1:1];
          carry_r <= fa_s[1];
          cnt_r   <= cnt_r + CNT_W'(1);
          // Final bit: the complete result becomes visible together with DONE.
          if (last_bit_s) begin
            sum_r  <= psum_next_s;
            cout_r <= fa_s[1];
          end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: an 8-bit instance for timing,
// overflow, back-to-back and reset scenarios, and a 3-bit instance swept exhaustively.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start3 = 1'b0;
  logic [2:0] a3 = 3'd0;
  logic [2:0] b3 = 3'd0;
  logic       cin3 = 1'b0;
  logic       busy3;
  logic       done3;
  logic [2:0] sum3;
  logic       cout3;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one 8-bit addition from IDLE and records every done pulse.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output logic [7:0] s, output logic co, output int dcount);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    dcount = 0; s = 8'hxx; co = 1'bx;
    for (int i = 0; i < 11; i++) begin
      step();
      if (done8) begin
        dcount++; s = sum8; co = cout8;
      end
    end
  endtask

  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic c,
                     output logic [2:0] s, output logic co, output int dcount);
    a3 = a; b3 = b; cin3 = c; start3 = 1'b1;
    step();
    start3 = 1'b0;
    dcount = 0; s = 3'bxxx; co = 1'bx;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done3) begin
        dcount++; s = sum3; co = cout3;
      end
    end
  endtask

  task automatic test_reset();
    step();
    step();
    total_cnt++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) $display("FAIL reset8: got %b, expected 0", {busy8, done8, cout8, sum8});
    else pass_cnt++;
    total_cnt++;
    if ({busy3, done3, cout3, sum3} !== 6'd0) $display("FAIL reset3: got %b, expected 0", {busy3, done3, cout3, sum3});
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({busy8, done8} !== 2'b00) $display("FAIL post_reset_idle: got %b, expected 00", {busy8, done8});
    else pass_cnt++;
  endtask

  task automatic test_latency();
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      total_cnt++;
      if ({busy8, done8, cout8, sum8} !== {2'b10, 1'b0, 8'h00})
        $display("FAIL latency_run%0d: got busy=%b done=%b sum=%h cout=%b, expected busy=1 done=0 sum=00 cout=0",
                 j, busy8, done8, sum8, cout8);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({busy8, done8, cout8, sum8} !== {2'b01, 1'b0, 8'h10})
      $display("FAIL latency_done: got busy=%b done=%b sum=%h cout=%b, expected busy=0 done=1 sum=10 cout=0",
               busy8, done8, sum8, cout8);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({busy8, done8, sum8} !== {2'b00, 8'h10})
      $display("FAIL latency_after: got busy=%b done=%b sum=%h, expected busy=0 done=0 sum=10", busy8, done8, sum8);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [7:0] s;
    logic co;
    int dc;
    op8(8'hFF, 8'h01, 1'b0, s, co, dc);
    total_cnt++;
    if ({dc[1:0], co, s} !== {2'd1, 1'b1, 8'h00}) $display("FAIL ovf_ff_01: got done_pulses=%0d cout=%b sum=%h, expected 1 1 00", dc, co, s);
    else pass_cnt++;
    op8(8'hFF, 8'hFF, 1'b1, s, co, dc);
    total_cnt++;
    if ({dc[1:0], co, s} !== {2'd1, 1'b1, 8'hFF}) $display("FAIL ovf_ff_ff_1: got done_pulses=%0d cout=%b sum=%h, expected 1 1 FF", dc, co, s);
    else pass_cnt++;
  endtask

  task automatic test_exhaustive3();
    logic [2:0] s;
    logic co;
    int dc;
    logic [3:0] exp_v;
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          op3(3'(ia), 3'(ib), 1'(ic), s, co, dc);
          exp_v = 4'(ia + ib + ic);
          total_cnt++;
          if ({co, s} !== exp_v || dc != 1)
            $display("FAIL exh3 a=%0d b=%0d c=%0d: got {cout,sum}=%0d pulses=%0d, expected %0d pulses=1",
                     ia, ib, ic, {co, s}, dc, exp_v);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    step();
    a8 = 8'h00; b8 = 8'h00;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j < 8) begin
        total_cnt++;
        if ({busy8, sum8, cout8} !== {1'b1, 8'hFF, 1'b1})
          $display("FAIL b2b_hold%0d: got busy=%b sum=%h cout=%b, expected busy=1 sum=FF cout=1", j, busy8, sum8, cout8);
        else pass_cnt++;
      end else if (j == 8) begin
        total_cnt++;
        if ({done8, cout8, sum8} !== {1'b1, 1'b0, 8'h77})
          $display("FAIL b2b_result: got done=%b cout=%b sum=%h, expected 1 0 77", done8, cout8, sum8);
        else pass_cnt++;
      end else if (j == 9) begin
        total_cnt++;
        if ({busy8, done8} !== 2'b00) $display("FAIL b2b_idle_gap: got busy=%b done=%b, expected 0 0", busy8, done8);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if ({busy8, done8} !== 2'b10) $display("FAIL b2b_reaccept: got busy=%b done=%b, expected 1 0", busy8, done8);
        else pass_cnt++;
      end
    end
    start8 = 1'b0;
    for (int j = 0; j < 10; j++) step();
    total_cnt++;
    if ({busy8, cout8, sum8} !== {1'b0, 1'b0, 8'h00})
      $display("FAIL b2b_second: got busy=%b cout=%b sum=%h, expected 0 0 00", busy8, cout8, sum8);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s;
    logic co;
    int dc;
    op8(8'h12, 8'h34, 1'b0, s, co, dc);
    total_cnt++;
    if ({dc[1:0], co, s} !== {2'd1, 1'b0, 8'h46}) $display("FAIL pre_abort: got pulses=%0d cout=%b sum=%h, expected 1 0 46", dc, co, s);
    else pass_cnt++;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int j = 0; j < 4; j++) step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy8, done8, cout8, sum8} !== 11'd0)
      $display("FAIL abort_immediate: got busy=%b done=%b cout=%b sum=%h, expected all 0", busy8, done8, cout8, sum8);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    dc = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (done8 || busy8) dc++;
    end
    total_cnt++;
    if (dc != 0 || sum8 !== 8'h00) $display("FAIL abort_quiet: got active_cycles=%0d sum=%h, expected 0 00", dc, sum8);
    else pass_cnt++;
    op8(8'h01, 8'h01, 1'b0, s, co, dc);
    total_cnt++;
    if ({dc[1:0], co, s} !== {2'd1, 1'b0, 8'h02}) $display("FAIL after_abort: got pulses=%0d cout=%b sum=%h, expected 1 0 02", dc, co, s);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_back_to_back();
    test_exhaustive3();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a new addition; sampled on the clk rising edge.
REQ-005 a  input  WIDTH  SHALL carry addend A; sampled only on the accepting edge.
REQ-006 b  input  WIDTH  SHALL carry addend B; sampled only on the accepting edge.
REQ-007 cin  input  1  SHALL carry the carry-in; sampled only on the accepting edge.
REQ-008 busy  output  1  SHALL be high while an addition is in progress (RUN state).
REQ-009 done  output  1  SHALL pulse high for exactly one cycle when a result is published.
REQ-010 sum  output  WIDTH  SHALL hold the most recently published sum, i.e. (a+b+cin) mod 2^WIDTH.
REQ-011 cout  output  1  SHALL hold the most recently published carry-out, i.e. bit WIDTH of a+b+cin.

Function
REQ-012 The datapath SHALL use one 1-bit full-adder cell per cycle.
- sum bit = x ^ y ^ c.
- carry = (x & y) | (c & (x ^ y)).
- Bits processed LSB first.
REQ-013 The state machine SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on an edge with start=1.
- On that edge: a and b load into internal shift registers, cin loads into the carry flip-flop, bit counter clears to 0.
REQ-015 In RUN, each edge SHALL:
- compute one bit from the LSBs of the shift registers and the carry flip-flop;
- shift that bit into an internal partial-sum register from the MSB end;
- update the carry flip-flop;
- shift both operand registers right by one;
- increment the counter.
REQ-016 RUN -> DONE on the edge that processes bit WIDTH-1 (the WIDTH-th RUN edge).
- On that same edge, sum and cout SHALL be updated with the complete result.
REQ-017 DONE -> IDLE unconditionally on the next edge; done=1 only while in DONE.
REQ-018 Latency: start accepted at edge k -> done high during the cycle after edge k+WIDTH; sum and cout valid from that cycle onward.
REQ-019 sum and cout SHALL NOT change during RUN; they hold the previous result until the next publication.
REQ-020 start SHALL be ignored in RUN and DONE; a and b changing during RUN SHALL NOT affect the result in flight.
REQ-021 Back-to-back operation: start held high continuously yields one accepted operation every WIDTH+2 cycles.
- Acceptance occurs on the first edge in IDLE.
REQ-022 The bit counter SHALL be wide enough to count to WIDTH-1 with no wrap-around before the RUN -> DONE transition.
REQ-023 Arithmetic SHALL be unsigned; no overflow flag beyond cout.

Reset
REQ-024 rst_n=0 SHALL, asynchronously:
- force state to IDLE;
- set busy=0, done=0, sum=0, cout=0;
- clear the carry flip-flop, counter, operand registers and partial-sum register.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave as from power-up.
REQ-026 Reset deassertion SHALL take effect on the clock domain with no state change until the first rising edge with rst_n=1.

Verification
REQ-027 WIDTH=8: a=0x0F, b=0x01, cin=0, start at edge k -> busy high edges k..k+8, done high only in cycle after edge k+8, sum=0x10, cout=0.
REQ-028 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-029 WIDTH=3 exhaustive: all 128 (a,b,cin) combinations -> every {cout,sum} equals a+b+cin, with one done pulse per operation.
REQ-030 WIDTH=8: start=1 with a=0x55, b=0x22 changed to a=0x00, b=0x00 during RUN while start stays high -> result 0x77, cout=0; next operation accepted exactly WIDTH+2 cycles after the first.
REQ-031 WIDTH=8: rst_n pulsed low for 1 cycle at RUN bit 4 of 0xAA+0x55 -> no done pulse, sum=0, cout=0, busy=0 immediately; a subsequent 0x01+0x01 -> sum=0x02.
